// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with bubble insertion, sign-mode decode and field split
// Optional saturating stall counter on port stall_cnt when IF_ID_STALL_CNT_EN is defined.
module if_id_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [5:0]  id_op,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm,
`ifdef IF_ID_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        id_sign
);

    logic if_sign;

    // Sign-extend for branches, signed/unsigned arithmetic immediates and memory offsets;
    // logical immediates and lui stay zero-extended.
    always_comb begin
        if_sign = 1'b0;
        case (if_instr[31:26])
            6'b000100, 6'b000101,
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
            6'b101000, 6'b101001, 6'b101011: if_sign = 1'b1;
            default:                         if_sign = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            id_pc    <= RESET_PC;
            id_pc4   <= RESET_PC + 32'd4;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            id_sign  <= 1'b0;
        end else if (!stall) begin
            id_pc    <= if_pc;
            id_pc4   <= if_pc + 32'd4;
            id_instr <= if_valid ? if_instr : NOP_INSTR;
            id_valid <= if_valid;
            id_sign  <= if_valid & if_sign;
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (stall && !flush && id_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign id_op    = id_instr[31:26];
    assign id_rs    = id_instr[25:21];
    assign id_rt    = id_instr[20:16];
    assign id_rd    = id_instr[15:11];
    assign id_shamt = id_instr[10:6];
    assign id_funct = id_instr[5:0];
    assign id_imm   = id_instr[15:0];

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - scoreboard bench for if_id_reg
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, stall, flush;
    logic [31:0] if_pc, if_instr;
    logic [31:0] id_pc, id_pc4, id_instr;
    logic        id_valid, id_sign;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        sign;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    if_id_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_valid (if_valid),
        .stall    (stall),
        .flush    (flush),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_instr (id_instr),
        .id_valid (id_valid),
        .id_op    (id_op),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_shamt (id_shamt),
        .id_funct (id_funct),
        .id_imm   (id_imm),
`ifdef IF_ID_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .id_sign  (id_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: each rising edge that was preceded by a checked stimulus pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "pc",    id_pc,    e.pc);
                chk(e.name, "pc4",   id_pc4,   e.pc4);
                chk(e.name, "instr", id_instr, e.instr);
                chk(e.name, "valid", {31'b0, id_valid}, {31'b0, e.valid});
                chk(e.name, "sign",  {31'b0, id_sign},  {31'b0, e.sign});
                chk(e.name, "op",    {26'b0, id_op},    {26'b0, e.instr[31:26]});
                chk(e.name, "rs",    {27'b0, id_rs},    {27'b0, e.instr[25:21]});
                chk(e.name, "rt",    {27'b0, id_rt},    {27'b0, e.instr[20:16]});
                chk(e.name, "rd",    {27'b0, id_rd},    {27'b0, e.instr[15:11]});
                chk(e.name, "shamt", {27'b0, id_shamt}, {27'b0, e.instr[10:6]});
                chk(e.name, "funct", {26'b0, id_funct}, {26'b0, e.instr[5:0]});
                chk(e.name, "imm",   {16'b0, id_imm},   {16'b0, e.instr[15:0]});
`ifdef IF_ID_STALL_CNT_EN
                chk(e.name, "stall_cnt", {16'b0, stall_cnt}, {16'b0, e.cnt});
`endif
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [31:0] pc, input logic [31:0] instr, input logic v);
        @(negedge clk);
        rst_n    = r;
        stall    = s;
        flush    = f;
        if_pc    = pc;
        if_instr = instr;
        if_valid = v;
    endtask

    task automatic step(input string name, input logic r, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] instr, input logic v,
                        input logic [31:0] epc, input logic [31:0] epc4, input logic [31:0] einstr,
                        input logic ev, input logic es, input logic [15:0] ecnt);
        exp_t e;
        drive(r, s, f, pc, instr, v);
        e.name = name; e.pc = epc; e.pc4 = epc4; e.instr = einstr;
        e.valid = ev; e.sign = es; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    initial begin
        int wait_cnt;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        if_pc = 32'h0; if_instr = 32'h0; if_valid = 1'b0;

        //    name          rst  stl  fl  if_pc         if_instr      v     pc            pc4           instr         v  s  cnt
        step("reset",       0,   0,   0,  32'h0000_1000, 32'h2008_FFFF, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'd0);
        step("load_addi",   1,   0,   0,  32'h0000_3000, 32'h2008_FFFF, 1,  32'h0000_3000, 32'h0000_3004, 32'h2008_FFFF, 1, 1, 16'd0);
        step("load_ori",    1,   0,   0,  32'h0000_3004, 32'h3508_00FF, 1,  32'h0000_3004, 32'h0000_3008, 32'h3508_00FF, 1, 0, 16'd0);
        step("stall1",      1,   1,   0,  32'h0000_3008, 32'h8C82_0004, 1,  32'h0000_3004, 32'h0000_3008, 32'h3508_00FF, 1, 0, 16'd1);
        step("stall2",      1,   1,   0,  32'h0000_300C, 32'hAC82_0004, 1,  32'h0000_3004, 32'h0000_3008, 32'h3508_00FF, 1, 0, 16'd2);
        step("stall3",      1,   1,   0,  32'h0000_3010, 32'h1022_0003, 0,  32'h0000_3004, 32'h0000_3008, 32'h3508_00FF, 1, 0, 16'd3);
        step("stall_flush", 1,   1,   1,  32'h0000_3014, 32'h2008_0001, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'd3);
        step("stall_empty", 1,   1,   0,  32'h0000_3018, 32'h2008_0001, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'd3);
        step("load_lw",     1,   0,   0,  32'h0000_0010, 32'h8C82_0004, 1,  32'h0000_0010, 32'h0000_0014, 32'h8C82_0004, 1, 1, 16'd3);
        step("load_invalid",1,   0,   0,  32'h0000_0014, 32'hAABB_CCDD, 0,  32'h0000_0014, 32'h0000_0018, 32'h0,        0, 0, 16'd3);
        step("load_lui",    1,   0,   0,  32'h0000_0018, 32'h3C01_1234, 1,  32'h0000_0018, 32'h0000_001C, 32'h3C01_1234, 1, 0, 16'd3);
        step("load_andi",   1,   0,   0,  32'h0000_001C, 32'h3022_00F0, 1,  32'h0000_001C, 32'h0000_0020, 32'h3022_00F0, 1, 0, 16'd3);
        step("load_sw",     1,   0,   0,  32'h0000_0020, 32'hAC82_FFF8, 1,  32'h0000_0020, 32'h0000_0024, 32'hAC82_FFF8, 1, 1, 16'd3);
        step("load_sltiu",  1,   0,   0,  32'h0000_0024, 32'h2C41_8000, 1,  32'h0000_0024, 32'h0000_0028, 32'h2C41_8000, 1, 1, 16'd3);
        step("load_j",      1,   0,   0,  32'h0000_0028, 32'h0800_0040, 1,  32'h0000_0028, 32'h0000_002C, 32'h0800_0040, 1, 0, 16'd3);
        step("load_rtype",  1,   0,   0,  32'h0000_002C, 32'h0043_0821, 1,  32'h0000_002C, 32'h0000_0030, 32'h0043_0821, 1, 0, 16'd3);
        step("load_beq",    1,   0,   0,  32'h0000_0030, 32'h1022_0003, 1,  32'h0000_0030, 32'h0000_0034, 32'h1022_0003, 1, 1, 16'd3);
        step("stall4",      1,   1,   0,  32'h0000_0034, 32'h2008_0001, 1,  32'h0000_0030, 32'h0000_0034, 32'h1022_0003, 1, 1, 16'd4);
        step("rst_in_stall",0,   1,   1,  32'h0000_0038, 32'h2008_0001, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'd0);
        step("load_wrap",   1,   0,   0,  32'hFFFF_FFFC, 32'h2401_0005, 1,  32'hFFFF_FFFC, 32'h0000_0000, 32'h2401_0005, 1, 1, 16'd0);
        step("flush_only",  1,   0,   1,  32'h0000_0040, 32'h2008_0001, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'd0);
        step("load_bne",    1,   0,   0,  32'h0000_0044, 32'h1443_FFFE, 1,  32'h0000_0044, 32'h0000_0048, 32'h1443_FFFE, 1, 1, 16'd0);

`ifdef IF_ID_STALL_CNT_EN
        // Run the counter into saturation, then confirm it holds.
        for (int i = 0; i < 65538; i++)
            drive(1, 1, 0, 32'h0000_0100, 32'h0000_0000, 1);
        step("cnt_sat",     1,   1,   0,  32'h0000_0100, 32'h0000_0000, 1,  32'h0000_0044, 32'h0000_0048, 32'h1443_FFFE, 1, 1, 16'hFFFF);
        step("cnt_sat_rst", 0,   1,   0,  32'h0000_0100, 32'h0000_0000, 1,  32'h0,        32'h4,        32'h0,        0, 0, 16'h0000);
`endif

        drive(1, 0, 0, 32'h0, 32'h0, 0);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
